// File: rtl/dcache_ctrl.sv
// MEM-stage L1 data cache: direct-mapped, write-back, write-allocate, 256-bit lines.
// Hits are served combinationally; misses write back a dirty victim, then refill.
module dcache_ctrl #(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 32 - 5 - IDX_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t               state_q, state_d;
    logic [NUM_SETS-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [255:0]         line_q [NUM_SETS];

    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [255:0]         mem_data_q, mem_data_d;

    logic                 req, hit, victim_dirty;
    logic                 fill, clean, store_hit;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     req_tag;
    logic [7:0]           woff;
    logic                 unused_addr_lsb;

    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign idx          = cpu_addr_i[5 +: IDX_W];
    assign req_tag      = cpu_addr_i[31 -: TAG_W];
    assign woff         = {cpu_addr_i[4:2], 5'b0};
    assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        fill         = 1'b0;
        clean        = 1'b0;
        store_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    store_hit = cpu_MemWrite_i;
                end else if (req && victim_dirty) begin
                    state_d      = WRITEBACK;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b1;
                    mem_addr_d   = {tag_q[idx], idx, 5'b0};
                    mem_data_d   = line_q[idx];
                end else if (req) begin
                    state_d      = REFILL;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {req_tag, idx, 5'b0};
                end
            end
            WRITEBACK: begin
                // enable stays high: the refill request follows the writeback directly
                if (mem_ack_i) begin
                    clean       = 1'b1;
                    state_d     = REFILL;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {req_tag, idx, 5'b0};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    fill         = 1'b1;
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (clean)     dirty_q[idx] <= 1'b0;
            if (store_hit) dirty_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[idx]  <= req_tag;
            line_q[idx] <= mem_data_i;
        end
        if (store_hit) line_q[idx][woff +: 32] <= cpu_data_i;
    end

    assign cpu_stall_o  = req && ((state_q != IDLE) || !hit);
    assign cpu_data_o   = (state_q == IDLE && req && hit && !cpu_MemWrite_i)
                          ? line_q[idx][woff +: 32] : 32'h0;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random accesses against a
// transaction-level cache/memory model that predicts per-cycle outputs.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_MemRead_i, cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    int checks = 0;
    int failures = 0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Model: cache contents per set and a sparse backing memory keyed by line address.
    bit           mv [16];
    bit           md [16];
    logic [22:0]  mt [16];
    logic [255:0] ml [16];
    logic [255:0] mem [logic [31:0]];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic get_line(input logic [31:0] a, output logic [255:0] l);
        if (!mem.exists(a))
            mem[a] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        l = mem[a];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // Starts at a negedge, ends at a negedge after the access completes.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input int nwb, input int nrf,
                             output int stalls, output logic [31:0] rdata, output logic [255:0] wbdata);
        int idx, wsel, total, ackwb, ackrf;
        logic [22:0] tg;
        bit hit, vd, en_e, wr_e;
        logic [31:0] vaddr, raddr, dout_e;
        logic [255:0] newline;
        idx   = int'(a[8:5]);
        wsel  = int'(a[4:2]);
        tg    = a[31:9];
        hit   = mv[idx] && (mt[idx] == tg);
        vd    = !hit && mv[idx] && md[idx];
        vaddr = {mt[idx], a[8:5], 5'b0};
        raddr = {a[31:5], 5'b0};
        if (hit) newline = ml[idx];
        else get_line(raddr, newline);
        total = hit ? 0 : 1 + (vd ? nwb : 0) + nrf;
        ackwb = nwb;
        ackrf = (vd ? nwb : 0) + nrf;
        dout_e = (rd && !wr) ? newline[wsel*32 +: 32] : 32'h0;
        cpu_MemRead_i = rd; cpu_MemWrite_i = wr; cpu_addr_i = a; cpu_data_i = wd;
        stalls = 0; rdata = 0; wbdata = 0;
        for (int k = 0; k <= total; k++) begin
            #1;
            en_e = (k >= 1) && (k < total);
            wr_e = en_e && vd && (k <= nwb);
            chk("stall", cpu_stall_o, k < total);
            chk("mem_enable", mem_enable_o, en_e);
            chk("cpu_data", cpu_data_o, (k == total) ? dout_e : 32'h0);
            if (en_e) begin
                chk("mem_write", mem_write_o, wr_e);
                chk("mem_addr", mem_addr_o, wr_e ? vaddr : raddr);
            end
            if (wr_e) begin
                chk("wb_data", mem_data_o, ml[idx]);
                wbdata = mem_data_o;
            end
            if (cpu_stall_o) stalls++;
            if (k == total) rdata = cpu_data_o;
            mem_ack_i  = !hit && (k >= 1) && ((vd && k == ackwb) || k == ackrf);
            mem_data_i = (k == ackrf) ? newline : {8{$urandom}};
            @(posedge clk_i);
            @(negedge clk_i);
            mem_ack_i = 1'b0;
        end
        if (!hit) begin
            if (vd) mem[vaddr] = ml[idx];
            ml[idx] = newline; mt[idx] = tg; mv[idx] = 1'b1; md[idx] = 1'b0;
        end
        if (wr) begin
            ml[idx][wsel*32 +: 32] = wd;
            md[idx] = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n, input bit ack);
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            mem_ack_i = ack;
            mem_data_i = {8{$urandom}};
            #1;
            chk("idle_stall", cpu_stall_o, 1'b0);
            chk("idle_data", cpu_data_o, 32'h0);
            chk("idle_enable", mem_enable_o, 1'b0);
            @(posedge clk_i);
            @(negedge clk_i);
            mem_ack_i = 1'b0;
        end
    endtask

    initial begin
        int st;
        logic [31:0] rd32, a;
        logic [255:0] wb, L, M;
        bit r, w;
        rst_i = 1'b1; cpu_MemRead_i = 0; cpu_MemWrite_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
        mem_ack_i = 0; mem_data_i = 0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            L[i*32 +: 32] = 32'h1111_0000 + i;
            M[i*32 +: 32] = 32'h3333_0000 + i;
        end
        mem[32'h100] = L;
        mem[32'h300] = M;
        @(negedge clk_i); @(negedge clk_i);
        #1;
        chk("rst_enable", mem_enable_o, 1'b0);
        chk("rst_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_mdata", mem_data_o, 256'h0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_cdata", cpu_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Clean miss, ack 5 cycles after request
        do_access(1, 0, 32'h100, 0, 1, 5, st, rd32, wb);
        chk("t1_stalls", st, 6);
        chk("t1_data", rd32, 32'h1111_0000);
        // Store hit then load hit
        do_access(0, 1, 32'h104, 32'hDEADBEEF, 1, 1, st, rd32, wb);
        chk("t2_store_stalls", st, 0);
        do_access(1, 0, 32'h104, 0, 1, 1, st, rd32, wb);
        chk("t2_stalls", st, 0);
        chk("t2_data", rd32, 32'hDEADBEEF);
        // Dirty conflict miss at set 8
        do_access(1, 0, 32'h304, 0, 3, 2, st, rd32, wb);
        chk("t3_stalls", st, 6);
        chk("t3_wb_word1", wb[63:32], 32'hDEADBEEF);
        chk("t3_wb_word0", wb[31:0], 32'h1111_0000);
        chk("t3_data", rd32, 32'h3333_0001);
        // Store miss with clean victim
        do_access(0, 1, 32'h208, 32'hCAFEF00D, 2, 4, st, rd32, wb);
        chk("t4_stalls", st, 5);
        do_access(1, 0, 32'h208, 0, 1, 1, st, rd32, wb);
        chk("t4_data", rd32, 32'hCAFEF00D);
        // Spurious ack while idle
        idle_cycles(3, 1'b1);

        // Reset during refill
        cpu_MemRead_i = 1; cpu_MemWrite_i = 0; cpu_addr_i = 32'h500;
        @(posedge clk_i); @(negedge clk_i);
        @(posedge clk_i); @(negedge clk_i);
        #1;
        chk("t5_enable_before", mem_enable_o, 1'b1);
        rst_i = 1'b1; cpu_MemRead_i = 0;
        #1;
        chk("t5_enable_rst", mem_enable_o, 1'b0);
        chk("t5_addr_rst", mem_addr_o, 32'h0);
        chk("t5_stall_rst", cpu_stall_o, 1'b0);
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        idle_cycles(2, 1'b1);
        do_access(1, 0, 32'h500, 0, 1, 2, st, rd32, wb);
        chk("t5_stalls", st, 3);

        // Random traffic with heavy set conflicts
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0)
                a = {$urandom} & 32'hFFFF_FFFC;
            else
                a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
            a[1:0] = 2'($urandom);
            case ($urandom_range(0, 3))
                0, 3:    begin r = 1; w = 0; end
                1:       begin r = 0; w = 1; end
                default: begin r = 1; w = 1; end
            endcase
            do_access(r, w, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4), st, rd32, wb);
            if ($urandom_range(0, 7) == 0) idle_cycles(1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
